// File: rtl/plateau_detect_ctrl.sv
// Plateau detector controller: flushes and fills an external running-sum block, then
// declares detection once the metric sum stays above a power-scaled threshold long enough.
module plateau_detect_ctrl #(
  parameter int DATA_WIDTH0  = 16,
  parameter int DATA_WIDTH1  = 16,
  parameter int LOG2_SUM_LEN = 6,
  parameter int MIN_PLATEAU  = 100
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   enable,
  input  logic                                   restart,
  input  logic signed [DATA_WIDTH0-1:0]          sample_in0,
  input  logic signed [DATA_WIDTH1-1:0]          sample_in1,
  input  logic                                   sample_in_valid,
  input  logic [3:0]                             thr_shift,
  output logic                                   sum_rstn,
  output logic signed [DATA_WIDTH0-1:0]          sum_data0,
  output logic signed [DATA_WIDTH1-1:0]          sum_data1,
  output logic                                   sum_data_valid,
  input  logic signed [DATA_WIDTH0+LOG2_SUM_LEN-1:0] sum_result0,
  input  logic signed [DATA_WIDTH1+LOG2_SUM_LEN-1:0] sum_result1,
  input  logic                                   sum_result_valid,
  output logic                                   detected,
  output logic [2:0]                             state,
  output logic [15:0]                            plateau_len
);

  localparam int RW0 = DATA_WIDTH0 + LOG2_SUM_LEN;
  localparam int RW1 = DATA_WIDTH1 + LOG2_SUM_LEN;
  localparam int CW  = (RW0 > RW1) ? RW0 : RW1;
  localparam int FW  = LOG2_SUM_LEN + 1;
  localparam logic [FW-1:0] FILL_LAST   = FW'((1 << LOG2_SUM_LEN) - 1);
  localparam logic [15:0]   PLATEAU_TGT = 16'(MIN_PLATEAU);
  localparam logic [15:0]   PLATEAU_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_FILL     = 3'd2,
    ST_SEARCH   = 3'd3,
    ST_DETECTED = 3'd4,
    ST_HOLD     = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic                    flush_cnt_q, flush_cnt_d;
  logic [FW-1:0]           fill_cnt_q, fill_cnt_d;
  logic [3:0]              shift_q, shift_d;
  logic [15:0]             plateau_q, plateau_d;
  logic                    sum_rstn_q, sum_rstn_d;
  logic signed [DATA_WIDTH0-1:0] sum_data0_q, sum_data0_d;
  logic signed [DATA_WIDTH1-1:0] sum_data1_q, sum_data1_d;
  logic                    sum_data_valid_q, sum_data_valid_d;
  logic                    detected_q, detected_d;

  logic signed [CW-1:0]    res0_ext_s, res1_ext_s, thr_s;
  logic [15:0]             plateau_inc_s;
  logic                    hit_s, rearm_s;

  // Hit qualification: both sums sign-extended to a common width before comparing.
  always_comb begin
    res0_ext_s    = CW'(sum_result0);
    res1_ext_s    = CW'(sum_result1);
    thr_s         = res1_ext_s >>> shift_q;
    hit_s         = sum_result_valid && !res0_ext_s[CW-1] && (|res0_ext_s) &&
                    (res0_ext_s >= thr_s);
    plateau_inc_s = (plateau_q == PLATEAU_MAX) ? plateau_q : (plateau_q + 16'd1);
    rearm_s       = enable && restart && (state_q != ST_IDLE);
  end

  // Next-state logic; enable low beats restart, restart beats everything else.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (rearm_s) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_FLUSH;
        ST_FLUSH:    state_d = flush_cnt_q ? ST_FILL : ST_FLUSH;
        ST_FILL:     state_d = (sum_data_valid_q && (fill_cnt_q == FILL_LAST)) ? ST_SEARCH : ST_FILL;
        ST_SEARCH:   state_d = (hit_s && (plateau_inc_s == PLATEAU_TGT)) ? ST_DETECTED : ST_SEARCH;
        ST_DETECTED: state_d = ST_HOLD;
        ST_HOLD:     state_d = ST_HOLD;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Counters and threshold latch follow the chosen transition.
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    plateau_d  = plateau_q;
    if ((state_d == ST_FLUSH) || (state_d == ST_IDLE)) begin
      fill_cnt_d = {FW{1'b0}};
      plateau_d  = 16'd0;
    end else if ((state_q == ST_FILL) && sum_data_valid_q) begin
      fill_cnt_d = fill_cnt_q + FW'(1);
    end else if ((state_q == ST_SEARCH) && sum_result_valid) begin
      plateau_d = hit_s ? plateau_inc_s : 16'd0;
    end else begin
      plateau_d = plateau_q;
    end

    if ((state_q == ST_FLUSH) && (state_d == ST_FLUSH) && !rearm_s) begin
      flush_cnt_d = 1'b1;
    end else begin
      flush_cnt_d = 1'b0;
    end

    if (state_q == ST_FLUSH) begin
      shift_d = thr_shift;
    end else begin
      shift_d = shift_q;
    end
  end

  // Registered outputs: forwarding path, sum-block reset and detection pulse.
  always_comb begin
    sum_rstn_d       = !((state_d == ST_IDLE) || (state_d == ST_FLUSH));
    detected_d       = (state_d == ST_DETECTED);
    sum_data0_d      = sum_data0_q;
    sum_data1_d      = sum_data1_q;
    sum_data_valid_d = 1'b0;
    if ((state_q == ST_FILL) || (state_q == ST_SEARCH) ||
        (state_q == ST_DETECTED) || (state_q == ST_HOLD)) begin
      sum_data0_d      = sample_in0;
      sum_data1_d      = sample_in1;
      sum_data_valid_d = sample_in_valid;
    end else begin
      sum_data_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= ST_IDLE;
      flush_cnt_q      <= 1'b0;
      fill_cnt_q       <= {FW{1'b0}};
      shift_q          <= 4'd0;
      plateau_q        <= 16'd0;
      sum_rstn_q       <= 1'b0;
      sum_data0_q      <= {DATA_WIDTH0{1'b0}};
      sum_data1_q      <= {DATA_WIDTH1{1'b0}};
      sum_data_valid_q <= 1'b0;
      detected_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      fill_cnt_q       <= fill_cnt_d;
      shift_q          <= shift_d;
      plateau_q        <= plateau_d;
      sum_rstn_q       <= sum_rstn_d;
      sum_data0_q      <= sum_data0_d;
      sum_data1_q      <= sum_data1_d;
      sum_data_valid_q <= sum_data_valid_d;
      detected_q       <= detected_d;
    end
  end

  assign state          = state_q;
  assign sum_rstn       = sum_rstn_q;
  assign sum_data0      = sum_data0_q;
  assign sum_data1      = sum_data1_q;
  assign sum_data_valid = sum_data_valid_q;
  assign detected       = detected_q;
  assign plateau_len    = plateau_q;

endmodule

// File: doc/plateau_detect_ctrl.md
PLATEAU_DETECT_CTRL -- requirements
Module: plateau_detect_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH0, default 16: width of channel-0 (correlation metric) samples.
REQ-002 SHALL have parameter DATA_WIDTH1, default 16: width of channel-1 (power) samples.
REQ-003 SHALL have parameter LOG2_SUM_LEN, default 6: log2 of the running-sum window, N = 2^LOG2_SUM_LEN.
REQ-004 SHALL have parameter MIN_PLATEAU, default 100: consecutive hits required to declare detection; 1 to 65535.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk  in  1  clock, all logic on rising edge; rstn  in  1  async active-low reset.
REQ-006 SHALL have ports: enable  in  1  run when high; restart  in  1  single-cycle re-arm request.
REQ-007 SHALL have ports: sample_in0  in  DATA_WIDTH0  signed metric; sample_in1  in  DATA_WIDTH1  signed power; sample_in_valid  in  1  sample strobe.
REQ-008 SHALL have ports: thr_shift  in  4  threshold shift, sampled only in FLUSH.
REQ-009 SHALL have ports toward the running-sum block: sum_rstn  out  1  its sync reset; sum_data0/sum_data1  out  DATA_WIDTH0/DATA_WIDTH1  forwarded samples; sum_data_valid  out  1.
REQ-010 SHALL have ports from the running-sum block: sum_result0  in  DATA_WIDTH0+LOG2_SUM_LEN  signed; sum_result1  in  DATA_WIDTH1+LOG2_SUM_LEN  signed; sum_result_valid  in  1.
REQ-011 SHALL have outputs: detected  out  1  one-cycle pulse; state  out  3  FSM state code; plateau_len  out  16  current consecutive-hit count.

Function
REQ-012 FSM states/codes: IDLE=0, FLUSH=1, FILL=2, SEARCH=3, DETECTED=4, HOLD=5; codes 6-7 unreachable, recover to IDLE.
REQ-013 IDLE -> FLUSH when enable=1; any state -> IDLE when enable=0 (priority over restart).
REQ-014 restart=1 with enable=1 in any state except IDLE -> FLUSH next cycle; hit counter and fill counter cleared.
REQ-015 FLUSH: sum_rstn=0 for exactly 2 cycles, thr_shift latched, then -> FILL; sum_rstn=1 in all other states except IDLE (IDLE holds sum_rstn=0).
REQ-016 Forwarding: in FILL, SEARCH, DETECTED, HOLD, sum_data0/1 and sum_data_valid are sample_in0/1 and sample_in_valid registered one cycle; in IDLE/FLUSH sum_data_valid=0, data held.
REQ-017 FILL: counts forwarded valid samples; after the N-th forwarded sample -> SEARCH; results arriving in FILL ignored.
REQ-018 Hit: sum_result_valid=1 AND sum_result0>0 AND sum_result0 >= (sum_result1 >>> latched thr_shift), compared signed at full result width with sign extension to the wider of the two.
REQ-019 SEARCH: on hit, plateau_len increments (saturating at 65535); on valid non-hit, plateau_len clears; no change without sum_result_valid.
REQ-020 When a hit brings plateau_len to MIN_PLATEAU -> DETECTED; detected=1 for the single DETECTED cycle, then -> HOLD.
REQ-021 HOLD: plateau_len frozen, detected=0, forwarding continues, exit only via restart or enable=0.
REQ-022 Simultaneous restart and detection-qualifying hit: restart wins, no detected pulse.
REQ-023 Samples arriving during FLUSH are dropped, not buffered.

Reset
REQ-024 rstn low SHALL asynchronously force: state=IDLE, sum_rstn=0, sum_data0/1=0, sum_data_valid=0, detected=0, plateau_len=0, fill counter=0, latched shift=0.
REQ-025 Reset deassertion mid-stream SHALL resume from IDLE; no output pulse on the release edge.

Verification
REQ-026 Fill: enable=1, 64 valid samples, LOG2_SUM_LEN=6 -> state 1 for 2 cycles, 2 during fill, 3 one cycle after the 64th forwarded sample.
REQ-027 Detect: SEARCH, thr_shift=1, result0=200, result1=300 every valid for 100 results -> detected pulses once on cycle after 100th hit, state 4 then 5, plateau_len=100.
REQ-028 Break: 50 hits, one miss (result0=100, result1=300, shift 0), 100 hits -> plateau_len 50, 0, then detected at 100th post-miss hit.
REQ-029 Restart: in HOLD assert restart one cycle -> sum_rstn low 2 cycles, plateau_len=0, FILL re-entered, no detected pulse.
REQ-030 Priority: restart coincident with 100th hit -> no detected pulse, state=1; enable=0 coincident with restart -> state=0.
REQ-031 Async reset: assert rstn=0 mid-SEARCH between clock edges -> all outputs at reset values before next edge.
